// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with byte-enable writes and per-entry valid bits.
// Define RF_BYPASS_EN for write-first same-address reads; the default build is read-first.

module regfile_2r1w_rport #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             re,
  input  logic [WIDTH-1:0] d,
  input  logic             hit,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rhit
);
  localparam int STAGES = 1;

  logic [STAGES-1:0] vld_pipe;

  // Data and hit hold when no request is issued; only the valid strobe drops.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
      rdata    <= '0;
      rhit     <= 1'b0;
    end else begin
      vld_pipe <= re;
      if (re) begin
        rdata <= d;
        rhit  <= hit;
      end
    end
  end

  assign rvalid = vld_pipe[STAGES-1];
endmodule

module regfile_2r1w #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int NB    = WIDTH / 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wbe,
  input  logic             re0,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  output logic             rvalid0,
  output logic             rhit0,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1,
  output logic             rhit1,
  output logic [DEPTH-1:0] valid_mask
);
  localparam int          NUM_PORTS = 2;
  localparam logic [AW:0] DEPTH_W   = DEPTH[AW:0];

  typedef struct packed {
    logic          re;
    logic [AW-1:0] addr;
  } rd_req_t;

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  logic             waddr_ok, wr_act;
  logic [WIDTH-1:0] wr_old, wr_merged;

  rd_req_t [NUM_PORTS-1:0]            rreq;
  logic    [NUM_PORTS-1:0]            rd_re, rd_hit, rd_ok;
  logic    [NUM_PORTS-1:0][WIDTH-1:0] rd_d;
  logic    [NUM_PORTS-1:0][WIDTH-1:0] rd_data;
  logic    [NUM_PORTS-1:0]            rd_vld, rd_rhit;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  // A write with no byte enables must not touch the valid bit, so it is not a write at all.
  assign wr_act   = we && waddr_ok && (|wbe);

  always_comb begin
    wr_old = '0;
    if (waddr_ok) wr_old = mem[waddr];
    wr_merged = wr_old;
    for (int b = 0; b < NB; b++)
      if (wbe[b]) wr_merged[8*b +: 8] = wdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mem        <= '0;
      valid_mask <= '0;
    end else if (wr_act) begin
      mem[waddr]        <= wr_merged;
      valid_mask[waddr] <= 1'b1;
    end
  end

  assign rreq[0] = '{re: re0, addr: raddr0};
  assign rreq[1] = '{re: re1, addr: raddr1};

  // Out-of-range addresses read as zero with no hit; bypass never applies to them.
  always_comb begin
    rd_re  = '0;
    rd_ok  = '0;
    rd_d   = '0;
    rd_hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_re[p] = rreq[p].re;
      rd_ok[p] = ({1'b0, rreq[p].addr} < DEPTH_W);
      if (rd_ok[p]) begin
        rd_d[p]   = mem[rreq[p].addr];
        rd_hit[p] = valid_mask[rreq[p].addr];
      end
`ifdef RF_BYPASS_EN
      if (rd_ok[p] && wr_act && (rreq[p].addr == waddr)) begin
        rd_d[p]   = wr_merged;
        rd_hit[p] = 1'b1;
      end
`endif
    end
  end

  regfile_2r1w_rport #(.WIDTH(WIDTH)) u_rport [NUM_PORTS-1:0] (
    .clk    (clk),
    .clr    (clr),
    .re     (rd_re),
    .d      (rd_d),
    .hit    (rd_hit),
    .rdata  (rd_data),
    .rvalid (rd_vld),
    .rhit   (rd_rhit)
  );

  assign rdata0  = rd_data[0];
  assign rvalid0 = rd_vld[0];
  assign rhit0   = rd_rhit[0];
  assign rdata1  = rd_data[1];
  assign rvalid1 = rd_vld[1];
  assign rhit1   = rd_rhit[1];
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench: 8x16 instance for main behaviour, 16-bit for byte enables, 8x12 for out-of-range.
`timescale 1ns/1ps
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int pass = 0;
  int total = 0;

  // dut8: WIDTH=8 DEPTH=16
  logic a_we = 0, a_re0 = 0, a_re1 = 0;
  logic [3:0] a_waddr = 0, a_raddr0 = 0, a_raddr1 = 0;
  logic [7:0] a_wdata = 0, a_rdata0, a_rdata1;
  logic [0:0] a_wbe = 0;
  logic a_rvalid0, a_rhit0, a_rvalid1, a_rhit1;
  logic [15:0] a_vm;

  // dut16: WIDTH=16 DEPTH=16
  logic b_we = 0, b_re0 = 0, b_re1 = 0;
  logic [3:0] b_waddr = 0, b_raddr0 = 0, b_raddr1 = 0;
  logic [15:0] b_wdata = 0, b_rdata0, b_rdata1;
  logic [1:0] b_wbe = 0;
  logic b_rvalid0, b_rhit0, b_rvalid1, b_rhit1;
  logic [15:0] b_vm;

  // dut12: WIDTH=8 DEPTH=12
  logic c_we = 0, c_re0 = 0, c_re1 = 0;
  logic [3:0] c_waddr = 0, c_raddr0 = 0, c_raddr1 = 0;
  logic [7:0] c_wdata = 0, c_rdata0, c_rdata1;
  logic [0:0] c_wbe = 0;
  logic c_rvalid0, c_rhit0, c_rvalid1, c_rhit1;
  logic [11:0] c_vm;

  regfile_2r1w #(.WIDTH(8), .DEPTH(16)) dut8 (
    .clk(clk), .clr(clr), .we(a_we), .waddr(a_waddr), .wdata(a_wdata), .wbe(a_wbe),
    .re0(a_re0), .raddr0(a_raddr0), .rdata0(a_rdata0), .rvalid0(a_rvalid0), .rhit0(a_rhit0),
    .re1(a_re1), .raddr1(a_raddr1), .rdata1(a_rdata1), .rvalid1(a_rvalid1), .rhit1(a_rhit1),
    .valid_mask(a_vm));

  regfile_2r1w #(.WIDTH(16), .DEPTH(16)) dut16 (
    .clk(clk), .clr(clr), .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .wbe(b_wbe),
    .re0(b_re0), .raddr0(b_raddr0), .rdata0(b_rdata0), .rvalid0(b_rvalid0), .rhit0(b_rhit0),
    .re1(b_re1), .raddr1(b_raddr1), .rdata1(b_rdata1), .rvalid1(b_rvalid1), .rhit1(b_rhit1),
    .valid_mask(b_vm));

  regfile_2r1w #(.WIDTH(8), .DEPTH(12)) dut12 (
    .clk(clk), .clr(clr), .we(c_we), .waddr(c_waddr), .wdata(c_wdata), .wbe(c_wbe),
    .re0(c_re0), .raddr0(c_raddr0), .rdata0(c_rdata0), .rvalid0(c_rvalid0), .rhit0(c_rhit0),
    .re1(c_re1), .raddr1(c_raddr1), .rdata1(c_rdata1), .rvalid1(c_rvalid1), .rhit1(c_rhit1),
    .valid_mask(c_vm));

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1; step();
    total++; if (a_vm !== 16'h0000) $display("FAIL reset_vm got %h exp 0000", a_vm); else pass++;
    total++; if (a_rvalid0 !== 1'b0) $display("FAIL reset_rvalid0 got %b exp 0", a_rvalid0); else pass++;
    clr = 0; a_re0 = 1; a_raddr0 = 3; step();
    a_re0 = 0;
    total++; if (a_rdata0 !== 8'h00) $display("FAIL reset_rdata0 got %h exp 00", a_rdata0); else pass++;
    total++; if (a_rhit0 !== 1'b0) $display("FAIL reset_rhit0 got %b exp 0", a_rhit0); else pass++;
    total++; if (a_rvalid0 !== 1'b1) $display("FAIL reset_rvalid0_rd got %b exp 1", a_rvalid0); else pass++;
    total++; if (a_vm !== 16'h0000) $display("FAIL reset_vm_rd got %h exp 0000", a_vm); else pass++;
  endtask

  task automatic test_write_read();
    a_we = 1; a_waddr = 5; a_wdata = 8'hA5; a_wbe = 1; step();
    a_we = 0; a_re0 = 1; a_re1 = 1; a_raddr0 = 5; a_raddr1 = 5; step();
    a_re0 = 0; a_re1 = 0;
    total++; if (a_rdata0 !== 8'hA5) $display("FAIL wr_rd_rdata0 got %h exp a5", a_rdata0); else pass++;
    total++; if (a_rdata1 !== 8'hA5) $display("FAIL wr_rd_rdata1 got %h exp a5", a_rdata1); else pass++;
    total++; if ({a_rhit0, a_rhit1} !== 2'b11) $display("FAIL wr_rd_rhit got %b exp 11", {a_rhit0, a_rhit1}); else pass++;
    total++; if ({a_rvalid0, a_rvalid1} !== 2'b11) $display("FAIL wr_rd_rvalid got %b exp 11", {a_rvalid0, a_rvalid1}); else pass++;
    total++; if (a_vm !== 16'h0020) $display("FAIL wr_rd_vm got %h exp 0020", a_vm); else pass++;
    // wbe=0 write is a no-op, valid bit included
    a_we = 1; a_waddr = 4; a_wdata = 8'h99; a_wbe = 0; step();
    a_we = 0; a_re0 = 1; a_raddr0 = 4; step();
    a_re0 = 0;
    total++; if (a_vm !== 16'h0020) $display("FAIL wbe0_vm got %h exp 0020", a_vm); else pass++;
    total++; if ({a_rdata0, a_rhit0} !== 9'h000) $display("FAIL wbe0_read got %h/%b exp 00/0", a_rdata0, a_rhit0); else pass++;
  endtask

  task automatic test_read_during_write();
    logic [7:0] exp_d;
    logic exp_h;
    a_we = 1; a_waddr = 7; a_wdata = 8'h11; a_wbe = 1; step();
    a_wdata = 8'h22; a_re0 = 1; a_raddr0 = 7; step();
`ifdef RF_BYPASS_EN
    exp_d = 8'h22;
`else
    exp_d = 8'h11;
`endif
    total++; if (a_rdata0 !== exp_d) $display("FAIL rdw_rdata0 got %h exp %h", a_rdata0, exp_d); else pass++;
    total++; if (a_rhit0 !== 1'b1) $display("FAIL rdw_rhit0 got %b exp 1", a_rhit0); else pass++;
    a_we = 0; step();
    total++; if (a_rdata0 !== 8'h22) $display("FAIL rdw_later got %h exp 22", a_rdata0); else pass++;
    // first write to entry 9 while reading it: hit depends on bypass
    a_we = 1; a_waddr = 9; a_wdata = 8'h3C; a_raddr0 = 9; step();
    a_we = 0; a_re0 = 0;
`ifdef RF_BYPASS_EN
    exp_d = 8'h3C; exp_h = 1'b1;
`else
    exp_d = 8'h00; exp_h = 1'b0;
`endif
    total++; if ({a_rdata0, a_rhit0} !== {exp_d, exp_h}) $display("FAIL rdw_fresh got %h/%b exp %h/%b", a_rdata0, a_rhit0, exp_d, exp_h); else pass++;
    total++; if (a_vm !== 16'h02A0) $display("FAIL rdw_vm got %h exp 02a0", a_vm); else pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      a_we = 1; a_waddr = 4'(i); a_wdata = 8'(8'h10 + i); a_wbe = 1; step();
    end
    a_we = 0;
    for (int i = 0; i < 4; i++) begin
      a_re0 = 1; a_raddr0 = 4'(i); a_re1 = 1; a_raddr1 = 4'(3 - i); step();
      total++;
      if (a_rdata0 !== 8'(8'h10 + i) || a_rdata1 !== 8'(8'h13 - i) || !a_rvalid0 || !a_rvalid1)
        $display("FAIL b2b_%0d got %h/%h v%b%b exp %h/%h v11", i, a_rdata0, a_rdata1,
                 a_rvalid0, a_rvalid1, 8'(8'h10 + i), 8'(8'h13 - i));
      else pass++;
    end
    a_re0 = 0; a_re1 = 0;
  endtask

  task automatic test_priority_hold();
    clr = 1; a_we = 1; a_waddr = 1; a_wdata = 8'hFF; a_wbe = 1; a_re0 = 1; a_raddr0 = 5; step();
    clr = 0; a_we = 0; a_raddr0 = 1;
    total++; if (a_vm !== 16'h0000) $display("FAIL prio_vm got %h exp 0000", a_vm); else pass++;
    total++; if ({a_rvalid0, a_rdata0} !== 9'h000) $display("FAIL prio_out got %b/%h exp 0/00", a_rvalid0, a_rdata0); else pass++;
    step();
    total++; if ({a_rdata0, a_rhit0} !== 9'h000) $display("FAIL prio_rd1 got %h/%b exp 00/0", a_rdata0, a_rhit0); else pass++;
    a_re0 = 0; a_we = 1; a_waddr = 3; a_wdata = 8'h5A; step();
    a_we = 0; a_re0 = 1; a_raddr0 = 3; step();
    a_re0 = 0;
    total++; if (a_rdata0 !== 8'h5A) $display("FAIL hold_rd got %h exp 5a", a_rdata0); else pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (a_rdata0 !== 8'h5A || a_rvalid0 !== 1'b0 || a_rhit0 !== 1'b1)
        $display("FAIL hold_%0d got %h v%b h%b exp 5a v0 h1", i, a_rdata0, a_rvalid0, a_rhit0);
      else pass++;
    end
  endtask

  task automatic test_byte_enables();
    logic [15:0] exp_d;
    b_we = 1; b_waddr = 2; b_wdata = 16'h1234; b_wbe = 2'b11; step();
    b_wdata = 16'hABCD; b_wbe = 2'b10; step();
    b_we = 0; b_re0 = 1; b_raddr0 = 2; step();
    total++; if ({b_rdata0, b_rhit0} !== {16'hAB34, 1'b1}) $display("FAIL be_merge got %h/%b exp ab34/1", b_rdata0, b_rhit0); else pass++;
    b_re0 = 0; b_we = 1; b_waddr = 4; b_wdata = 16'hFFFF; b_wbe = 2'b00; step();
    b_we = 0; b_re1 = 1; b_raddr1 = 4; step();
    b_re1 = 0;
    total++; if (b_vm !== 16'h0004) $display("FAIL be_zero_vm got %h exp 0004", b_vm); else pass++;
    total++; if ({b_rdata1, b_rhit1} !== 17'h0) $display("FAIL be_zero_rd got %h/%b exp 0000/0", b_rdata1, b_rhit1); else pass++;
    // partial-byte write while reading the same entry
    b_we = 1; b_waddr = 2; b_wdata = 16'h5678; b_wbe = 2'b01; b_re0 = 1; b_raddr0 = 2; step();
`ifdef RF_BYPASS_EN
    exp_d = 16'hAB78;
`else
    exp_d = 16'hAB34;
`endif
    b_we = 0; b_re0 = 0;
    total++; if (b_rdata0 !== exp_d) $display("FAIL be_rdw got %h exp %h", b_rdata0, exp_d); else pass++;
  endtask

  task automatic test_out_of_range();
    c_we = 1; c_waddr = 3; c_wdata = 8'h33; c_wbe = 1; step();
    c_waddr = 11; c_wdata = 8'hBB; step();
    c_waddr = 13; c_wdata = 8'h77; c_re0 = 1; c_raddr0 = 13; c_re1 = 1; c_raddr1 = 3; step();
    c_we = 0; c_re0 = 0;
    total++; if (c_vm !== 12'h808) $display("FAIL oor_vm got %h exp 808", c_vm); else pass++;
    total++; if ({c_rvalid0, c_rhit0, c_rdata0} !== {2'b10, 8'h00}) $display("FAIL oor_rdw got v%b h%b %h exp v1 h0 00", c_rvalid0, c_rhit0, c_rdata0); else pass++;
    total++; if (c_rdata1 !== 8'h33) $display("FAIL oor_pre got %h exp 33", c_rdata1); else pass++;
    c_raddr1 = 14; step();
    total++; if ({c_rvalid1, c_rhit1, c_rdata1} !== {2'b10, 8'h00}) $display("FAIL oor_rd1 got v%b h%b %h exp v1 h0 00", c_rvalid1, c_rhit1, c_rdata1); else pass++;
    c_raddr1 = 11; step();
    c_re1 = 0;
    total++; if ({c_rhit1, c_rdata1} !== {1'b1, 8'hBB}) $display("FAIL oor_last got h%b %h exp h1 bb", c_rhit1, c_rdata1); else pass++;
  endtask

  initial begin
    #2;
    test_reset();
    test_write_read();
    test_read_during_write();
    test_back_to_back();
    test_priority_hold();
    test_byte_enables();
    test_out_of_range();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
